// File: rtl/ram_arbiter_2p.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter_2p
// Function : Two-port round-robin arbiter and sequencer for a single-port SRAM
//            macro, with per-port response routing and out-of-range errors.
// Revision : 1.0
// ============================================================================
module ram_arbiter_2p #(
  parameter int AW          = 13,
  parameter int DW          = 32,
  parameter int DEPTH_WORDS = 6144,
  parameter bit RR_EN       = 1'b1
) (
  input  logic            CLK,
  input  logic            RESETn,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [DW/8-1:0] req0_we,
  input  logic [AW-1:0]   req0_addr,
  input  logic [DW-1:0]   req0_wdata,
  output logic            rsp0_valid,
  output logic            rsp0_err,
  output logic [DW-1:0]   rsp0_rdata,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [DW/8-1:0] req1_we,
  input  logic [AW-1:0]   req1_addr,
  input  logic [DW-1:0]   req1_wdata,
  output logic            rsp1_valid,
  output logic            rsp1_err,
  output logic [DW-1:0]   rsp1_rdata,
  output logic            ram_EN,
  output logic [DW/8-1:0] ram_WE,
  output logic [AW-1:0]   ram_A,
  output logic [DW-1:0]   ram_Di,
  input  logic [DW-1:0]   ram_Do
);

  localparam int          C_BW    = DW / 8;
  // One extra bit so a depth equal to 2**AW does not truncate to zero.
  localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH_WORDS);

  logic            r_prio1;
  logic            r_rsp_valid;
  logic            r_rsp_port;
  logic            r_rsp_read;
  logic            r_rsp_err;
  logic            w_grant0;
  logic            w_grant1;
  logic            w_xfer;
  logic            w_in_range;
  logic [AW-1:0]   w_addr;
  logic [C_BW-1:0] w_we;
  logic [DW-1:0]   w_wdata;
  logic [DW-1:0]   w_rdata;

  // r_prio1 set means port 1 wins the next conflict; cleared at reset.
  always_comb begin
    w_grant1 = req1_valid & (!req0_valid | !RR_EN | r_prio1);
    w_grant0 = req0_valid & !w_grant1;
    w_xfer   = w_grant0 | w_grant1;
  end

  always_comb begin
    w_addr  = '0;
    w_we    = '0;
    w_wdata = '0;
    if (w_grant1) begin
      w_addr  = req1_addr;
      w_we    = req1_we;
      w_wdata = req1_wdata;
    end else if (w_grant0) begin
      w_addr  = req0_addr;
      w_we    = req0_we;
      w_wdata = req0_wdata;
    end
  end

  assign w_in_range = ({1'b0, w_addr} < C_DEPTH);
  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign ram_EN     = w_xfer & w_in_range;
  assign ram_WE     = w_we;
  assign ram_A      = w_addr;
  assign ram_Di     = w_wdata;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_prio1     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_port  <= 1'b0;
      r_rsp_read  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_prio1 <= w_grant0;
      end
      r_rsp_valid <= w_xfer;
      r_rsp_port  <= w_grant1;
      r_rsp_read  <= ~|w_we;
      r_rsp_err   <= ~w_in_range;
    end
  end

  // Read data passes straight through from the macro in the response cycle.
  assign w_rdata    = (r_rsp_valid & r_rsp_read & ~r_rsp_err) ? ram_Do : '0;
  assign rsp0_valid = r_rsp_valid & ~r_rsp_port;
  assign rsp1_valid = r_rsp_valid & r_rsp_port;
  assign rsp0_err   = rsp0_valid & r_rsp_err;
  assign rsp1_err   = rsp1_valid & r_rsp_err;
  assign rsp0_rdata = rsp0_valid ? w_rdata : '0;
  assign rsp1_rdata = rsp1_valid ? w_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter_2p.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter_2p
// Function : Table-driven check of ram_arbiter_2p with SRAM models, plus
//            reset and fixed-priority contention sequences.
// Revision : 1.0
// ============================================================================
module tb_ram_arbiter_2p;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        v0, v1;
  logic [3:0]  we0, we1;
  logic [12:0] a0, a1;
  logic [31:0] d0, d1;

  logic        rdy0_a, rdy1_a, r0v_a, r0e_a, r1v_a, r1e_a, en_a;
  logic [31:0] r0d_a, r1d_a, di_a, do_a;
  logic [3:0]  we_a;
  logic [12:0] ad_a;
  logic        rdy0_b, rdy1_b, r0v_b, r0e_b, r1v_b, r1e_b, en_b;
  logic [31:0] r0d_b, r1d_b, di_b, do_b;
  logic [3:0]  we_b;
  logic [12:0] ad_b;

  logic [31:0] mem_a [0:6143];
  logic [31:0] mem_b [0:6143];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  ram_arbiter_2p #(.AW(13), .DW(32), .DEPTH_WORDS(6144), .RR_EN(1'b1)) dut_rr (
    .CLK(CLK), .RESETn(RESETn),
    .req0_valid(v0), .req0_ready(rdy0_a), .req0_we(we0), .req0_addr(a0), .req0_wdata(d0),
    .rsp0_valid(r0v_a), .rsp0_err(r0e_a), .rsp0_rdata(r0d_a),
    .req1_valid(v1), .req1_ready(rdy1_a), .req1_we(we1), .req1_addr(a1), .req1_wdata(d1),
    .rsp1_valid(r1v_a), .rsp1_err(r1e_a), .rsp1_rdata(r1d_a),
    .ram_EN(en_a), .ram_WE(we_a), .ram_A(ad_a), .ram_Di(di_a), .ram_Do(do_a)
  );

  ram_arbiter_2p #(.AW(13), .DW(32), .DEPTH_WORDS(6144), .RR_EN(1'b0)) dut_fp (
    .CLK(CLK), .RESETn(RESETn),
    .req0_valid(v0), .req0_ready(rdy0_b), .req0_we(we0), .req0_addr(a0), .req0_wdata(d0),
    .rsp0_valid(r0v_b), .rsp0_err(r0e_b), .rsp0_rdata(r0d_b),
    .req1_valid(v1), .req1_ready(rdy1_b), .req1_we(we1), .req1_addr(a1), .req1_wdata(d1),
    .rsp1_valid(r1v_b), .rsp1_err(r1e_b), .rsp1_rdata(r1d_b),
    .ram_EN(en_b), .ram_WE(we_b), .ram_A(ad_b), .ram_Di(di_b), .ram_Do(do_b)
  );

  // SRAM models: 1-cycle read latency, byte-lane writes
  always @(posedge CLK) begin
    if (en_a) begin
      if (we_a == 4'h0) do_a <= mem_a[ad_a];
      else for (int b = 0; b < 4; b++) if (we_a[b]) mem_a[ad_a][8*b +: 8] <= di_a[8*b +: 8];
    end
    if (en_b) begin
      if (we_b == 4'h0) do_b <= mem_b[ad_b];
      else for (int b = 0; b < 4; b++) if (we_b[b]) mem_b[ad_b][8*b +: 8] <= di_b[8*b +: 8];
    end
  end

  typedef struct {
    logic v0; logic [3:0] we0; logic [12:0] a0; logic [31:0] d0;
    logic v1; logic [3:0] we1; logic [12:0] a1; logic [31:0] d1;
    logic rdy0; logic rdy1; logic en; logic [12:0] ea; logic [3:0] ewe; logic [31:0] edi;
    logic r0v; logic r0e; logic [31:0] r0d;
    logic r1v; logic r1e; logic [31:0] r1d;
  } vec_t;

  vec_t tab [23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv0, input logic [3:0] iwe0, input logic [12:0] ia0,
                       input logic [31:0] id0, input logic iv1, input logic [3:0] iwe1,
                       input logic [12:0] ia1, input logic [31:0] id1);
    v0 = iv0; we0 = iwe0; a0 = ia0; d0 = id0;
    v1 = iv1; we1 = iwe1; a1 = ia1; d1 = id1;
  endtask

  initial begin
    logic [12:0] pa;
    RESETn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6144; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[5] = 32'hDEADBEEF;
    mem_b[5] = 32'hDEADBEEF;
    for (int j = 0; j < 6; j++) begin
      pa = 13'(j * 'h400);
      mem_a[pa] = 32'hA000_0000 | 32'(pa);
      mem_b[pa] = 32'hA000_0000 | 32'(pa);
    end

    //            v0 we0  a0       d0            v1 we1  a1       d1             rdy0 rdy1 en ea       ewe  edi            r0v r0e r0d             r1v r1e r1d
    tab[0]  = '{0, 0,   0,       0,            0, 0,   0,       0,             0, 0, 0, 0,       0,   0,             0, 0, 0,            0, 0, 0};
    tab[1]  = '{1, 0,   'h005,   0,            0, 0,   0,       0,             1, 0, 1, 'h005,   0,   0,             0, 0, 0,            0, 0, 0};
    tab[2]  = '{0, 0,   0,       0,            0, 0,   0,       0,             0, 0, 0, 0,       0,   0,             1, 0, 'hDEADBEEF,   0, 0, 0};
    tab[3]  = '{0, 0,   0,       0,            1, 'hF, 'h17FF,  'h11223344,    0, 1, 1, 'h17FF,  'hF, 'h11223344,    0, 0, 0,            0, 0, 0};
    tab[4]  = '{0, 0,   0,       0,            1, 'h1, 'h17FF,  'hAA,          0, 1, 1, 'h17FF,  'h1, 'hAA,          0, 0, 0,            1, 0, 0};
    tab[5]  = '{0, 0,   0,       0,            1, 0,   'h17FF,  0,             0, 1, 1, 'h17FF,  0,   0,             0, 0, 0,            1, 0, 0};
    tab[6]  = '{0, 0,   0,       0,            0, 0,   0,       0,             0, 0, 0, 0,       0,   0,             0, 0, 0,            1, 0, 'h112233AA};
    tab[7]  = '{1, 0,   'h400,   0,            1, 0,   'h800,   0,             1, 0, 1, 'h400,   0,   0,             0, 0, 0,            0, 0, 0};
    tab[8]  = '{1, 0,   'hC00,   0,            1, 0,   'h800,   0,             0, 1, 1, 'h800,   0,   0,             1, 0, 'hA0000400,   0, 0, 0};
    tab[9]  = '{1, 0,   'hC00,   0,            1, 0,   'h1000,  0,             1, 0, 1, 'hC00,   0,   0,             0, 0, 0,            1, 0, 'hA0000800};
    tab[10] = '{1, 0,   'h1400,  0,            1, 0,   'h1000,  0,             0, 1, 1, 'h1000,  0,   0,             1, 0, 'hA0000C00,   0, 0, 0};
    tab[11] = '{1, 0,   'h1400,  0,            0, 0,   0,       0,             1, 0, 1, 'h1400,  0,   0,             0, 0, 0,            1, 0, 'hA0001000};
    tab[12] = '{0, 0,   0,       0,            0, 0,   0,       0,             0, 0, 0, 0,       0,   0,             1, 0, 'hA0001400,   0, 0, 0};
    tab[13] = '{1, 0,   'h1800,  0,            0, 0,   0,       0,             1, 0, 0, 'h1800,  0,   0,             0, 0, 0,            0, 0, 0};
    tab[14] = '{1, 'hF, 'h1FFF,  'h55,         0, 0,   0,       0,             1, 0, 0, 'h1FFF,  'hF, 'h55,          1, 1, 0,            0, 0, 0};
    tab[15] = '{0, 0,   0,       0,            0, 0,   0,       0,             0, 0, 0, 0,       0,   0,             1, 1, 0,            0, 0, 0};
    for (int j = 0; j < 7; j++) begin
      tab[16+j] = '{default: 0};
      if (j < 6) begin
        pa = 13'(j * 'h400);
        tab[16+j].v1 = 1; tab[16+j].a1 = pa;
        tab[16+j].rdy1 = 1; tab[16+j].en = 1; tab[16+j].ea = pa;
      end
      if (j > 0) begin
        tab[16+j].r1v = 1;
        tab[16+j].r1d = 32'hA000_0000 | 32'((j - 1) * 'h400);
      end
    end

    repeat (2) @(posedge CLK);
    #1;
    chk("reset rsp0_valid", 32'(r0v_a), 0);
    chk("reset rsp1_valid", 32'(r1v_a), 0);
    @(negedge CLK) RESETn = 1'b1;

    for (int i = 0; i < 23; i++) begin
      @(posedge CLK);
      #1;
      drive(tab[i].v0, tab[i].we0, tab[i].a0, tab[i].d0, tab[i].v1, tab[i].we1, tab[i].a1, tab[i].d1);
      @(negedge CLK);
      chk($sformatf("row%0d req0_ready", i), 32'(rdy0_a), 32'(tab[i].rdy0));
      chk($sformatf("row%0d req1_ready", i), 32'(rdy1_a), 32'(tab[i].rdy1));
      chk($sformatf("row%0d ram_EN", i),     32'(en_a),   32'(tab[i].en));
      chk($sformatf("row%0d ram_A", i),      32'(ad_a),   32'(tab[i].ea));
      chk($sformatf("row%0d ram_WE", i),     32'(we_a),   32'(tab[i].ewe));
      chk($sformatf("row%0d ram_Di", i),     di_a,        tab[i].edi);
      chk($sformatf("row%0d rsp0_valid", i), 32'(r0v_a),  32'(tab[i].r0v));
      chk($sformatf("row%0d rsp0_err", i),   32'(r0e_a),  32'(tab[i].r0e));
      chk($sformatf("row%0d rsp0_rdata", i), r0d_a,       tab[i].r0d);
      chk($sformatf("row%0d rsp1_valid", i), 32'(r1v_a),  32'(tab[i].r1v));
      chk($sformatf("row%0d rsp1_err", i),   32'(r1e_a),  32'(tab[i].r1e));
      chk($sformatf("row%0d rsp1_rdata", i), r1d_a,       tab[i].r1d);
    end

    // Reset asserted mid-cycle right after a read transfer
    @(posedge CLK);
    #1 drive(1, 0, 'h005, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("rst_seq xfer ready", 32'(rdy0_a), 1);
    @(posedge CLK);
    #2 RESETn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_seq rsp0_valid now", 32'(r0v_a), 0);
    chk("rst_seq rsp0_rdata now", r0d_a, 0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_seq rsp0_valid later", 32'(r0v_a), 0);
    chk("rst_seq rsp1_valid later", 32'(r1v_a), 0);
    @(negedge CLK) RESETn = 1'b1;

    // Contention after reset: RR grants 0,1,0,1; fixed priority always port 1
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK);
      #1;
      if (k < 4) drive(1, 0, 'h400, 0, 1, 0, 'h800, 0);
      else       drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge CLK);
      if (k < 4) begin
        chk($sformatf("cont%0d rr req0_ready", k), 32'(rdy0_a), 32'(k % 2 == 0));
        chk($sformatf("cont%0d rr req1_ready", k), 32'(rdy1_a), 32'(k % 2 == 1));
        chk($sformatf("cont%0d fp req0_ready", k), 32'(rdy0_b), 0);
        chk($sformatf("cont%0d fp req1_ready", k), 32'(rdy1_b), 1);
      end
      chk($sformatf("cont%0d rr rsp0_valid", k), 32'(r0v_a), 32'(k == 1 || k == 3));
      chk($sformatf("cont%0d rr rsp1_valid", k), 32'(r1v_a), 32'(k == 2 || k == 4));
      chk($sformatf("cont%0d rr rsp0_rdata", k), r0d_a, (k == 1 || k == 3) ? 32'hA0000400 : 32'h0);
      chk($sformatf("cont%0d rr rsp1_rdata", k), r1d_a, (k == 2 || k == 4) ? 32'hA0000800 : 32'h0);
      chk($sformatf("cont%0d fp rsp1_valid", k), 32'(r1v_b), 32'(k > 0));
      chk($sformatf("cont%0d fp rsp0_valid", k), 32'(r0v_b), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
